// File: rtl/rst_sequencer.sv
// Staged reset controller: debounces PLL lock, then releases N reset domains in order.
// Latency: locked pin to FILTER entry is 3 edges; stage k released LOCK_FILTER+(k+1)*HOLD_CYCLES edges after FILTER entry.
// Backpressure: none; lock loss re-asserts every reset, sw_rst restarts from the lock filter.
module rst_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                sw_rst,
  output logic [N_STAGES-1:0] rst_out,
  output logic                seq_done
);

  localparam int ST_W = $clog2(N_STAGES + 1);

  localparam logic [CNT_W-1:0]    FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ST_W-1:0]     LAST_STAGE = ST_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] STAGE_ONE  = N_STAGES'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Two-flop synchronizer for the asynchronous PLL lock
  logic sync1_q;
  logic locked_s_q;

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [ST_W-1:0]     stage_q,    stage_d;
  logic [N_STAGES-1:0] rst_out_q,  rst_out_d;
  logic                seq_done_q, seq_done_d;

  // Next-state: lock loss beats sw_rst, which beats normal sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;

    if ((state_q != WAIT_LOCK) && !locked_s_q) begin
      state_d    = WAIT_LOCK;
      cnt_d      = '0;
      stage_d    = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end else if ((state_q != WAIT_LOCK) && sw_rst) begin
      state_d    = FILTER;
      cnt_d      = '0;
      stage_d    = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = FILTER;
            cnt_d   = '0;
          end
        end
        FILTER: begin
          if (cnt_q == FILT_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q & ~(STAGE_ONE << stage_q);
            stage_d   = stage_q + 1'b1;
            if (stage_q == LAST_STAGE) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          rst_out_d  = '0;
          seq_done_d = 1'b1;
        end
        default: begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          stage_d    = '0;
          rst_out_d  = '1;
          seq_done_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      stage_q    <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       sw_rst = 1'b0;
  logic [2:0] rst_out_a;
  logic       seq_done_a;
  logic [0:0] rst_out_b;
  logic       seq_done_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rst_sequencer #(.N_STAGES(3), .LOCK_FILTER(8), .HOLD_CYCLES(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst(sw_rst),
    .rst_out(rst_out_a), .seq_done(seq_done_a)
  );

  rst_sequencer #(.N_STAGES(1), .LOCK_FILTER(1), .HOLD_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst(sw_rst),
    .rst_out(rst_out_b), .seq_done(seq_done_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sequencing is "active" from the edge the filter starts;
  // the number of released stages follows from elapsed edges alone.
  int en   = 0;
  bit ms1  = 0, ms2 = 0;
  bit act_a = 0, act_b = 0;
  int st_a = 0, st_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms1 = 0; ms2 = 0; act_a = 0; act_b = 0;
    end else begin
      en = en + 1;
      if (!act_a) begin
        if (ms2) begin act_a = 1; st_a = en; end
      end else if (!ms2) act_a = 0;
      else if (sw_rst) st_a = en;
      if (!act_b) begin
        if (ms2) begin act_b = 1; st_b = en; end
      end else if (!ms2) act_b = 0;
      else if (sw_rst) st_b = en;
      ms2 = ms1;
      ms1 = locked;
    end
  end

  function automatic int released(bit act, int el, int lf, int hold, int n);
    int r;
    if (!act || el < lf + hold) return 0;
    r = (el - lf) / hold;
    if (r > n) r = n;
    return r;
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int ra, rb;
      logic [2:0] ea;
      ra = released(act_a, en - st_a, 8, 16, 3);
      rb = released(act_b, en - st_b, 1, 1, 1);
      for (int i = 0; i < 3; i++) ea[i] = (i >= ra);
      chk("model_rst_a", {29'd0, rst_out_a}, {29'd0, ea});
      chk("model_done_a", {31'd0, seq_done_a}, {31'd0, ra == 3});
      chk("model_rst_b", {31'd0, rst_out_b}, {31'd0, rb == 0});
      chk("model_done_b", {31'd0, seq_done_b}, {31'd0, rb == 1});
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    go(5);
    chk("reset_rst_a", {29'd0, rst_out_a}, 32'h7);
    chk("reset_done_a", {31'd0, seq_done_a}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    go(2);

    // Power-up: locked rises; next edge is edge 1
    locked = 1'b1;
    go(4);  chk("pu_b_e4", {31'd0, rst_out_b}, 32'h1);
    go(1);  chk("pu_b_e5", {31'd0, rst_out_b}, 32'h0);
            chk("pu_b_done_e5", {31'd0, seq_done_b}, 32'h1);
    go(21); chk("pu_a_e26", {29'd0, rst_out_a}, 32'h7);
    go(1);  chk("pu_a_e27", {29'd0, rst_out_a}, 32'h6);
    go(15); chk("pu_a_e42", {29'd0, rst_out_a}, 32'h6);
    go(1);  chk("pu_a_e43", {29'd0, rst_out_a}, 32'h4);
    go(15); chk("pu_a_e58", {29'd0, rst_out_a}, 32'h4);
            chk("pu_done_e58", {31'd0, seq_done_a}, 32'h0);
    go(1);  chk("pu_a_e59", {29'd0, rst_out_a}, 32'h0);
            chk("pu_done_e59", {31'd0, seq_done_a}, 32'h1);
    go(5);

    // Lock loss in RUN: first edge after the drop is E
    locked = 1'b0;
    go(2);  chk("loss_e1", {29'd0, rst_out_a}, 32'h0);
    go(1);  chk("loss_e2", {29'd0, rst_out_a}, 32'h7);
            chk("loss_done_e2", {31'd0, seq_done_a}, 32'h0);
    go(4);

    // Re-lock with a one-cycle glitch sampled at edge 6
    locked = 1'b1;
    go(5);
    locked = 1'b0;
    go(1);
    locked = 1'b1;
    go(26); chk("glitch_e32", {29'd0, rst_out_a}, 32'h7);
    go(1);  chk("glitch_e33", {29'd0, rst_out_a}, 32'h6);
    go(40); chk("glitch_run", {29'd0, rst_out_a}, 32'h0);

    // sw_rst in RUN sampled at edge E
    sw_rst = 1'b1;
    go(1);
    sw_rst = 1'b0;
            chk("sw_e0", {29'd0, rst_out_a}, 32'h7);
            chk("sw_done_e0", {31'd0, seq_done_a}, 32'h0);
    go(23); chk("sw_e23", {29'd0, rst_out_a}, 32'h7);
    go(1);  chk("sw_e24", {29'd0, rst_out_a}, 32'h6);
    go(16); chk("sw_e40", {29'd0, rst_out_a}, 32'h4);
    go(16); chk("sw_e56", {29'd0, rst_out_a}, 32'h0);
            chk("sw_done_e56", {31'd0, seq_done_a}, 32'h1);
    go(4);

    // Simultaneous sw_rst and lock loss in RELEASE after stage 0 released
    sw_rst = 1'b1;
    go(1);
    sw_rst = 1'b0;
    go(29); chk("sim_pre", {29'd0, rst_out_a}, 32'h6);
    locked = 1'b0;
    go(2);
    sw_rst = 1'b1;
    go(1);
    sw_rst = 1'b0;
            chk("sim_rst", {29'd0, rst_out_a}, 32'h7);
    go(10); chk("sim_hold", {29'd0, rst_out_a}, 32'h7);
    locked = 1'b1;
    go(26); chk("sim_relock_e26", {29'd0, rst_out_a}, 32'h7);
    go(1);  chk("sim_relock_e27", {29'd0, rst_out_a}, 32'h6);

    // Asynchronous reset mid-RELEASE
    go(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", {29'd0, rst_out_a}, 32'h7);
    chk("arst_done_a", {31'd0, seq_done_a}, 32'h0);
    chk("arst_b", {31'd0, rst_out_b}, 32'h1);
    go(2);
    rst_n = 1'b1;
    go(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
